// File: rtl/active_list_exec_state_tracker_pkg.sv
// Shared types and constants for the active-list execution-state tracker.
package active_list_exec_state_tracker_pkg;

  localparam int AL_ENTRY_NUM   = 64;
  localparam int ALLOC_WIDTH    = 2;
  localparam int COMMIT_WIDTH   = 2;
  localparam int WRITE_PORT_NUM = 4;

  localparam int AL_PTR_W = $clog2(AL_ENTRY_NUM);
  localparam int AL_CNT_W = AL_PTR_W + 1;

  typedef logic [AL_PTR_W-1:0] ActiveListIndexPath;
  typedef logic [AL_CNT_W-1:0] ActiveListCountPath;

  typedef enum logic [1:0] {
    EXEC_NOT_FINISHED = 2'd0,
    EXEC_SUCCESS      = 2'd1,
    EXEC_REFETCH_THIS = 2'd2,
    EXEC_REFETCH_NEXT = 2'd3
  } ExecutionState;

  typedef enum logic {
    TRK_RUN     = 1'b0,
    TRK_RECOVER = 1'b1
  } TrackerPhase;

endpackage

// File: rtl/active_list_flush_range_decoder.sv
// Per-entry flush mask for the half-open range [head, tail), with wrap-around.
// An equal head and tail describes an empty range; flushAllInsns selects every entry.
module active_list_flush_range_decoder #(
  parameter int ENTRY_NUM = 64,
  parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
  input  logic [PTR_W-1:0]     flushRangeHeadPtr,
  input  logic [PTR_W-1:0]     flushRangeTailPtr,
  input  logic                 flushAllInsns,
  output logic [ENTRY_NUM-1:0] flushMask
);

  logic [PTR_W-1:0] entryIdx;

  // Mark each entry that lies inside the (possibly wrapped) flush range
  always_comb begin
    flushMask = '0;
    entryIdx  = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      entryIdx = PTR_W'(i);
      if (flushRangeHeadPtr <= flushRangeTailPtr)
        flushMask[i] = (entryIdx >= flushRangeHeadPtr) && (entryIdx < flushRangeTailPtr);
      else
        flushMask[i] = (entryIdx >= flushRangeHeadPtr) || (entryIdx < flushRangeTailPtr);
      if (flushAllInsns)
        flushMask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/active_list_exec_state_tracker.sv
// Tracks execution state of in-flight active-list entries and presents the
// in-order commit window. Optional macro RSD_AL_COMMIT_BYPASS_EN forwards
// same-cycle completion writes into the commit window.
module active_list_exec_state_tracker #(
  parameter int AL_ENTRY_NUM   = active_list_exec_state_tracker_pkg::AL_ENTRY_NUM,
  parameter int WRITE_PORT_NUM = active_list_exec_state_tracker_pkg::WRITE_PORT_NUM,
  parameter int ALLOC_WIDTH    = active_list_exec_state_tracker_pkg::ALLOC_WIDTH,
  parameter int COMMIT_WIDTH   = active_list_exec_state_tracker_pkg::COMMIT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(ALLOC_WIDTH):0]    allocNum,
  input  logic [WRITE_PORT_NUM-1:0]       wrValid,
  input  logic [$clog2(AL_ENTRY_NUM)-1:0] wrPtr [WRITE_PORT_NUM],
  input  logic [1:0]                      wrState [WRITE_PORT_NUM],
  input  logic                            toRecoveryPhase,
  input  logic                            flushAllInsns,
  input  logic [$clog2(AL_ENTRY_NUM)-1:0] flushRangeHeadPtr,
  input  logic [$clog2(AL_ENTRY_NUM)-1:0] flushRangeTailPtr,
  input  logic [$clog2(COMMIT_WIDTH):0]   commitAck,
  output logic [$clog2(AL_ENTRY_NUM)-1:0] headPtr,
  output logic [$clog2(AL_ENTRY_NUM)-1:0] tailPtr,
  output logic [$clog2(AL_ENTRY_NUM):0]   count,
  output logic                            allocReady,
  output logic [COMMIT_WIDTH-1:0]         commitValid,
  output logic [1:0]                      commitState [COMMIT_WIDTH],
  output logic                            refetchReq
);

  import active_list_exec_state_tracker_pkg::*;

  localparam int PTR_W = $clog2(AL_ENTRY_NUM);
  localparam int CNT_W = PTR_W + 1;

  TrackerPhase             phase, phaseNext;
  logic                    flushEvent;
  logic [AL_ENTRY_NUM-1:0] validBits, validNext, flushMask;
  logic [1:0]              stateArray   [AL_ENTRY_NUM];
  logic [1:0]              stateWritten [AL_ENTRY_NUM];
  logic [1:0]              stateNext    [AL_ENTRY_NUM];
  logic [1:0]              windowState  [AL_ENTRY_NUM];
  logic [PTR_W-1:0]        winIdx, allocIdx, ackIdx;
  logic [PTR_W-1:0]        headNext, tailNext;
  logic [CNT_W-1:0]        countNext;
  logic                    windowChain;
  int                      allocEff, ackLimit, ackEff;

  active_list_flush_range_decoder #(
    .ENTRY_NUM (AL_ENTRY_NUM),
    .PTR_W     (PTR_W)
  ) flushDecoder (
    .flushRangeHeadPtr (flushRangeHeadPtr),
    .flushRangeTailPtr (flushRangeTailPtr),
    .flushAllInsns     (flushAllInsns),
    .flushMask         (flushMask)
  );

  // Recovery FSM: the flush lands on the edge where toRecoveryPhase is first seen high
  always_comb begin
    phaseNext  = phase;
    flushEvent = 1'b0;
    case (phase)
      TRK_RUN: begin
        if (toRecoveryPhase) begin
          phaseNext  = TRK_RECOVER;
          flushEvent = 1'b1;
        end
      end
      TRK_RECOVER: begin
        if (!toRecoveryPhase)
          phaseNext = TRK_RUN;
      end
      default: phaseNext = TRK_RUN;
    endcase
  end

  // Allocation gating; an allocation request without allocReady is ignored
  always_comb begin
    allocReady = (phase == TRK_RUN) && ((int'(count) + ALLOC_WIDTH) <= AL_ENTRY_NUM);
    allocEff   = 0;
    if (allocReady && !flushEvent)
      allocEff = (int'(allocNum) > ALLOC_WIDTH) ? ALLOC_WIDTH : int'(allocNum);
  end

  // Merge completion writes into the state array; later ports override earlier ones
  always_comb begin
    stateWritten = stateArray;
    for (int p = 0; p < WRITE_PORT_NUM; p++) begin
      if (wrValid[p] && validBits[wrPtr[p]])
        stateWritten[wrPtr[p]] = wrState[p];
    end
  end

  // Select what the commit window looks at: forwarded writes or registered state only
  always_comb begin
`ifdef RSD_AL_COMMIT_BYPASS_EN
    windowState = stateWritten;
`else
    windowState = stateArray;
`endif
  end

  // In-order commit window: stops at the first non-SUCCESS entry, which is still shown
  always_comb begin
    commitValid = '0;
    winIdx      = '0;
    windowChain = (phase == TRK_RUN);
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      winIdx         = headPtr + PTR_W'(i);
      commitState[i] = windowState[winIdx];
      commitValid[i] = windowChain && validBits[winIdx] &&
                       (windowState[winIdx] != EXEC_NOT_FINISHED);
      windowChain    = commitValid[i] && (windowState[winIdx] == EXEC_SUCCESS);
    end
    refetchReq = commitValid[0] && (commitState[0] != EXEC_SUCCESS);
  end

  // Clamp the retire count to the contiguous committable prefix
  always_comb begin
    ackLimit = 0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commitValid[i])
        ackLimit = i + 1;
    end
    ackEff = (int'(commitAck) > ackLimit) ? ackLimit : int'(commitAck);
  end

  // Next entry state: writes, then allocation, then retire, then flush (highest priority)
  always_comb begin
    stateNext = stateWritten;
    validNext = validBits;
    allocIdx  = '0;
    ackIdx    = '0;
    for (int a = 0; a < ALLOC_WIDTH; a++) begin
      if (a < allocEff) begin
        allocIdx            = tailPtr + PTR_W'(a);
        stateNext[allocIdx] = EXEC_NOT_FINISHED;
        validNext[allocIdx] = 1'b1;
      end
    end
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (c < ackEff) begin
        ackIdx            = headPtr + PTR_W'(c);
        validNext[ackIdx] = 1'b0;
      end
    end
    if (flushEvent)
      validNext = validNext & ~flushMask;
  end

  // Next pointers and occupancy; a flush rewinds the tail and recomputes the count
  always_comb begin
    headNext = headPtr + PTR_W'(ackEff);
    if (flushEvent && flushAllInsns) begin
      tailNext  = headNext;
      countNext = '0;
    end else if (flushEvent) begin
      tailNext  = flushRangeHeadPtr;
      countNext = {1'b0, PTR_W'(flushRangeHeadPtr - headNext)};
    end else begin
      tailNext  = tailPtr + PTR_W'(allocEff);
      countNext = count + CNT_W'(allocEff) - CNT_W'(ackEff);
    end
  end

  // State registers; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= TRK_RUN;
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      validBits <= '0;
      for (int i = 0; i < AL_ENTRY_NUM; i++)
        stateArray[i] <= EXEC_NOT_FINISHED;
    end else begin
      phase      <= phaseNext;
      headPtr    <= headNext;
      tailPtr    <= tailNext;
      count      <= countNext;
      validBits  <= validNext;
      stateArray <= stateNext;
    end
  end

endmodule

// File: tb/tb_active_list_exec_state_tracker.sv
// Directed, table-driven bench for the active-list execution-state tracker.
module tb_active_list_exec_state_tracker;

  typedef struct {
    int allocNum;
    int commitAck;
    int wrMask;
    int p0, s0, p1, s1, p2, s2, p3, s3;
    int eh, et, ec, ear, ecv, cs0, cs1, rf;
  } TrackerVector;

  localparam int NUM_VEC = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] allocNum;
  logic [3:0] wrValid;
  logic [5:0] wrPtr [4];
  logic [1:0] wrState [4];
  logic       toRecoveryPhase;
  logic       flushAllInsns;
  logic [5:0] flushRangeHeadPtr;
  logic [5:0] flushRangeTailPtr;
  logic [1:0] commitAck;
  logic [5:0] headPtr;
  logic [5:0] tailPtr;
  logic [6:0] count;
  logic       allocReady;
  logic [1:0] commitValid;
  logic [1:0] commitState [2];
  logic       refetchReq;

  int vectorsApplied = 0;
  int missCount = 0;
  TrackerVector vecs [NUM_VEC];

  active_list_exec_state_tracker dut (
    .clk               (clk),
    .rst               (rst),
    .allocNum          (allocNum),
    .wrValid           (wrValid),
    .wrPtr             (wrPtr),
    .wrState           (wrState),
    .toRecoveryPhase   (toRecoveryPhase),
    .flushAllInsns     (flushAllInsns),
    .flushRangeHeadPtr (flushRangeHeadPtr),
    .flushRangeTailPtr (flushRangeTailPtr),
    .commitAck         (commitAck),
    .headPtr           (headPtr),
    .tailPtr           (tailPtr),
    .count             (count),
    .allocReady        (allocReady),
    .commitValid       (commitValid),
    .commitState       (commitState),
    .refetchReq        (refetchReq)
  );

  always #5 clk = ~clk;

  task automatic setIdle();
    allocNum      = 2'd0;
    commitAck     = 2'd0;
    wrValid       = 4'd0;
    flushAllInsns = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wrPtr[p]   = 6'd0;
      wrState[p] = 2'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic setWrite(input int port, input int ptr, input int st);
    wrValid[port] = 1'b1;
    wrPtr[port]   = 6'(ptr);
    wrState[port] = 2'(st);
  endtask

  task automatic cmpField(input string name, input string field, input logic [7:0] act, input int exp);
    if (act !== 8'(exp)) begin
      missCount++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int eh, input int et, input int ec,
                             input int ear, input int ecv, input int cs0, input int cs1,
                             input int rf);
    vectorsApplied++;
    cmpField(name, "headPtr", 8'(headPtr), eh);
    cmpField(name, "tailPtr", 8'(tailPtr), et);
    cmpField(name, "count", 8'(count), ec);
    cmpField(name, "allocReady", 8'(allocReady), ear);
    cmpField(name, "commitValid", 8'(commitValid), ecv);
    cmpField(name, "commitState0", 8'(commitState[0]), cs0);
    cmpField(name, "commitState1", 8'(commitState[1]), cs1);
    cmpField(name, "refetchReq", 8'(refetchReq), rf);
  endtask

  task automatic applyStimulus(input TrackerVector v);
    allocNum   = 2'(v.allocNum);
    commitAck  = 2'(v.commitAck);
    wrValid    = 4'(v.wrMask);
    wrPtr[0]   = 6'(v.p0);
    wrState[0] = 2'(v.s0);
    wrPtr[1]   = 6'(v.p1);
    wrState[1] = 2'(v.s1);
    wrPtr[2]   = 6'(v.p2);
    wrState[2] = 2'(v.s2);
    wrPtr[3]   = 6'(v.p3);
    wrState[3] = 2'(v.s3);
    tick();
  endtask

  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset", 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // alloc, ack, wrMask, p0,s0,p1,s1,p2,s2,p3,s3, head,tail,count,allocReady,commitValid,cs0,cs1,refetch
    vecs[0]  = '{2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 3,  0, 1, 1, 1, 0, 0, 0, 0,  0, 2, 2, 1, 3, 1, 1, 0};
    vecs[2]  = '{0, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  2, 4, 2, 1, 0, 0, 0, 0};
    vecs[4]  = '{2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  2, 6, 4, 1, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0,  2, 6, 4, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 0, 1,  2, 1, 0, 0, 0, 0, 0, 0,  2, 6, 4, 1, 3, 1, 1, 0};
    vecs[7]  = '{0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  3, 6, 3, 1, 1, 1, 0, 0};
    vecs[8]  = '{0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  4, 6, 2, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 3,  4, 2, 5, 1, 0, 0, 0, 0,  4, 6, 2, 1, 1, 2, 1, 1};
    vecs[10] = '{0, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0,  5, 6, 1, 1, 1, 1, 0, 0};
    vecs[11] = '{0, 0, 9,  5, 1, 0, 0, 0, 0, 5, 3,  5, 6, 1, 1, 1, 3, 0, 1};
    vecs[12] = '{2, 0, 1,  6, 1, 0, 0, 0, 0, 0, 0,  5, 8, 3, 1, 1, 3, 0, 1};
    vecs[13] = '{0, 0, 3, 20, 1, 6, 1, 0, 0, 0, 0,  5, 8, 3, 1, 1, 3, 1, 1};
    vecs[14] = '{0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  6, 8, 2, 1, 1, 1, 0, 0};
    vecs[15] = '{0, 1, 3,  6, 2, 7, 1, 0, 0, 0, 0,  7, 8, 1, 1, 1, 1, 0, 0};
    vecs[16] = '{0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  8, 8, 0, 1, 0, 0, 0, 0};

    setIdle();
    toRecoveryPhase   = 1'b0;
    flushRangeHeadPtr = 6'd0;
    flushRangeTailPtr = 6'd0;
    resetDut();

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].ec, vecs[i].ear,
                  vecs[i].ecv, vecs[i].cs0, vecs[i].cs1, vecs[i].rf);
    end

    // Fill the list completely, wrapping the tail back to 0
    resetDut();
    for (int k = 1; k <= 32; k++) begin
      allocNum = 2'd2;
      tick();
      checkOutput($sformatf("fill%0d", k), 0, (2 * k) % 64, 2 * k,
                  ((2 * k + 2) <= 64) ? 1 : 0, 0, 0, 0, 0);
    end
    allocNum = 2'd2;
    tick();
    checkOutput("allocWhenFull", 0, 0, 64, 0, 0, 0, 0, 0);
    setWrite(0, 0, 1);
    setWrite(1, 1, 1);
    tick();
    checkOutput("fullWindow", 0, 0, 64, 0, 3, 1, 1, 0);
    commitAck = 2'd2;
    tick();
    checkOutput("commitFromFull", 2, 0, 62, 1, 0, 0, 0, 0);

    // Finish every remaining entry, then drain the head up to 60
    for (int base = 2; base < 64; base += 4) begin
      for (int p = 0; p < 4; p++) begin
        if (base + p < 64)
          setWrite(p, base + p, 1);
      end
      tick();
    end
    checkOutput("allSuccess", 2, 0, 62, 1, 3, 1, 1, 0);
    for (int j = 0; j < 29; j++) begin
      commitAck = 2'd2;
      tick();
    end
    checkOutput("drainTo60", 60, 0, 4, 1, 3, 1, 1, 0);
    allocNum = 2'd2;
    tick();
    allocNum = 2'd2;
    tick();
    checkOutput("wrapAlloc", 60, 4, 8, 1, 3, 1, 1, 0);

    // Range flush [62,4) across the wrap, with same-cycle writes
    toRecoveryPhase   = 1'b1;
    flushRangeHeadPtr = 6'd62;
    flushRangeTailPtr = 6'd4;
    setWrite(0, 1, 1);
    setWrite(1, 61, 2);
    tick();
    checkOutput("rangeFlush", 60, 62, 2, 0, 0, 1, 2, 0);
    setWrite(0, 60, 3);
    tick();
    checkOutput("recoverWrite", 60, 62, 2, 0, 0, 3, 2, 0);
    toRecoveryPhase = 1'b0;
    tick();
    checkOutput("recoverExit", 60, 62, 2, 1, 1, 3, 2, 1);
    commitAck = 2'd2;
    tick();
    checkOutput("clampAck", 61, 62, 1, 1, 1, 2, 1, 1);
    commitAck = 2'd1;
    tick();
    checkOutput("flushedEntry", 62, 62, 0, 1, 0, 1, 1, 0);

    // Full flush
    allocNum = 2'd2;
    tick();
    checkOutput("allocAfterFlush", 62, 0, 2, 1, 0, 0, 0, 0);
    setWrite(0, 62, 1);
    tick();
    checkOutput("partialWindow", 62, 0, 2, 1, 1, 1, 0, 0);
    toRecoveryPhase   = 1'b1;
    flushAllInsns     = 1'b1;
    flushRangeHeadPtr = 6'd0;
    flushRangeTailPtr = 6'd0;
    tick();
    checkOutput("flushAll", 62, 62, 0, 0, 0, 1, 0, 0);
    toRecoveryPhase = 1'b0;
    tick();
    checkOutput("flushAllExit", 62, 62, 0, 1, 0, 1, 0, 0);

    // Asynchronous reset in mid-cycle with traffic pending
    for (int k = 0; k < 5; k++) begin
      allocNum = 2'd2;
      tick();
    end
    setWrite(0, 62, 1);
    setWrite(1, 63, 1);
    tick();
    checkOutput("preReset", 62, 8, 10, 1, 3, 1, 1, 0);
    setWrite(0, 0, 1);
    setWrite(1, 1, 1);
    commitAck = 2'd2;
    allocNum  = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", 0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("resetHeld", 0, 0, 0, 1, 0, 0, 0, 0);
    setIdle();
    rst = 1'b0;
    tick();
    checkOutput("afterReset", 0, 0, 0, 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, missCount);
    $finish;
  end

endmodule
